// File: rtl/mem_unit.sv
// mem_unit: shared single-port word memory serving instruction fetch and data load/store,
// with fetch/data arbitration, configurable wait states and the core's pipeline stall.
module mem_unit #(
    parameter int    DEPTH       = 1024,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_mem_r_addr,
    output logic [31:0] i_mem_r_data,
    input  logic [31:0] d_mem_w_addr,
    input  logic [31:0] d_mem_w_data,
    input  logic        d_mem_we,
    input  logic        d_mem_oe,
    output logic [31:0] d_mem_r_data,
    output logic        stall,
    output logic        d_done,
    output logic        bus_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] W = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [31:2]   addr_q, addr_e;
    logic [31:0]   wdata_q, wdata_e;
    logic          we_q, oe_q, we_e, oe_e;
    logic          last, grant, own_d, op, oor_e, oor_q;
    logic [AW-1:0] idx_e;
    logic [31:0]   mem [DEPTH];
    logic          unused_ok;

    assign unused_ok = ^{i_mem_r_addr[1:0], d_mem_w_addr[1:0]};

    // "_e" signals are the access as seen at this edge: live inputs on a grant, latched copies otherwise,
    // so a zero-wait access can complete on its own grant edge.
    always_comb begin
        last      = state != IDLE && cnt == 4'd0;
        grant     = state == IDLE || last;
        own_d     = (d_mem_we || d_mem_oe) && state != DATA;
        state_nxt = grant ? (own_d ? DATA : FETCH) : state;
        cnt_nxt   = grant ? W : cnt - 4'd1;
        addr_e    = grant ? (own_d ? d_mem_w_addr[31:2] : i_mem_r_addr[31:2]) : addr_q;
        wdata_e   = grant ? d_mem_w_data : wdata_q;
        we_e      = grant ? own_d && d_mem_we : we_q;
        oe_e      = grant ? own_d && d_mem_oe : oe_q;
        op        = rst && cnt_nxt == 4'd0;
        oor_e     = addr_e[31:AW+2] != '0;
        idx_e     = addr_e[AW+1:2];
        oor_q     = addr_q[31:AW+2] != '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            oe_q         <= 1'b0;
            i_mem_r_data <= '0;
            d_mem_r_data <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            addr_q  <= addr_e;
            wdata_q <= wdata_e;
            we_q    <= we_e;
            oe_q    <= oe_e;
            if (op && state_nxt == FETCH)
                i_mem_r_data <= oor_e ? '0 : mem[idx_e];
            if (op && state_nxt == DATA && oe_e)
                d_mem_r_data <= oor_e ? '0 : mem[idx_e];
        end
    end

    // No reset on the array; op is gated by rst so a store in flight is dropped on reset.
    always_ff @(posedge clk) begin
        if (op && state_nxt == DATA && we_e && !oor_e)
            mem[idx_e] <= wdata_e;
    end

    assign stall   = !(last && state == FETCH);
    assign d_done  = last && state == DATA;
    assign bus_err = last && oor_q;
endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: drives mem_unit like a core that freezes on stall, checking against a word-array
// model of the memory with per-instruction cycle cost, done/error pulse counts and read data.
module tb_mem_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        d_we = 1'b0, d_oe = 1'b0;
    logic [31:0] i_rd0, d_rd0, i_rd3, d_rd3, i_rd, d_rd;
    logic        stall0, done0, berr0, stall3, done3, berr3, stall, done, berr;
    bit          sel = 1'b0;
    int          w = 0;
    int          ncmp = 0, nfail = 0;
    logic [31:0] m [1024];
    bit          known [1024];
    logic [31:0] exp_drd = '0;

    always #5 clk = ~clk;

    mem_unit #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .i_mem_r_addr(i_addr), .i_mem_r_data(i_rd0),
        .d_mem_w_addr(d_addr), .d_mem_w_data(d_wdata), .d_mem_we(d_we), .d_mem_oe(d_oe),
        .d_mem_r_data(d_rd0), .stall(stall0), .d_done(done0), .bus_err(berr0)
    );

    mem_unit #(.DEPTH(1024), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .i_mem_r_addr(i_addr), .i_mem_r_data(i_rd3),
        .d_mem_w_addr(d_addr), .d_mem_w_data(d_wdata), .d_mem_we(d_we), .d_mem_oe(d_oe),
        .d_mem_r_data(d_rd3), .stall(stall3), .d_done(done3), .bus_err(berr3)
    );

    assign i_rd  = sel ? i_rd3 : i_rd0;
    assign d_rd  = sel ? d_rd3 : d_rd0;
    assign stall = sel ? stall3 : stall0;
    assign done  = sel ? done3 : done0;
    assign berr  = sel ? berr3 : berr0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic bit oor(logic [31:0] a);
        return a[31:12] != 20'd0;
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        return ($urandom_range(0, 9) == 0) ? (a | 32'h1000) : (a & 32'h3F);
    endfunction

    task automatic check_reset_outputs();
        check("rst_i_data", i_rd, 32'd0);
        check("rst_d_data", d_rd, 32'd0);
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_d_done", 32'(done), 32'd0);
        check("rst_bus_err", 32'(berr), 32'd0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("idle_stall", 32'(stall), 32'd1);
        exp_drd = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_outputs();
        release_reset();
    endtask

    // One core instruction: a fetch plus an optional data access; called at a negedge while the
    // previous instruction's completing cycle (or the post-reset idle cycle) is being observed.
    task automatic instr(logic [31:0] fa, bit we, bit oe, logic [31:0] da, logic [31:0] dd);
        int n, dn, be, exp_be;
        bit data, fchk;
        logic [31:0] exp_i;
        data = we || oe;
        exp_be = ((data && oor(da)) ? 1 : 0) + (oor(fa) ? 1 : 0);
        if (oe) exp_drd = oor(da) ? 32'd0 : m[da[11:2]];
        if (we && !oor(da)) begin
            m[da[11:2]] = dd;
            known[da[11:2]] = 1'b1;
        end
        fchk = oor(fa) || known[fa[11:2]];
        exp_i = oor(fa) ? 32'd0 : m[fa[11:2]];
        i_addr = fa;
        d_addr = da;
        d_wdata = dd;
        d_we = we;
        d_oe = oe;
        n = 0;
        dn = 0;
        be = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
            dn += int'(done);
            be += int'(berr);
        end while (stall && n < 64);
        check("cycles", n, (data ? 2 : 1) * (w + 1));
        check("d_done_count", dn, 32'(data));
        check("bus_err_count", be, exp_be);
        if (fchk) check("fetch_data", i_rd, exp_i);
        check("load_data", d_rd, exp_drd);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) known[i] = 1'b0;
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) instr(32'd0, 1'b1, 1'b0, 32'(i * 4), 32'hA0 + 32'(i));
    endtask

    task automatic random_run(int count);
        int k;
        for (int i = 0; i < count; i++) begin
            k = $urandom_range(0, 3);
            instr(rnd_addr(), k == 1 || k == 3, k == 2 || k == 3, rnd_addr(), $urandom);
        end
    endtask

    initial begin
        clear_model();
        #2 check_reset_outputs();
        release_reset();

        // Zero wait states
        preload();
        do_reset();
        for (int i = 0; i < 4; i++) instr(32'(i * 4), 1'b0, 1'b0, 32'd0, 32'd0);
        instr(32'h10, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
        instr(32'h14, 1'b0, 1'b1, 32'h40, 32'd0);
        instr(32'h0, 1'b1, 1'b0, 32'h14, 32'h11);
        instr(32'h4, 1'b1, 1'b1, 32'h14, 32'h22);
        instr(32'h14, 1'b0, 1'b1, 32'h14, 32'd0);
        instr(32'h0, 1'b1, 1'b0, 32'h1000, 32'h55);
        instr(32'h0, 1'b0, 1'b1, 32'h1000, 32'd0);
        instr(32'h1000, 1'b0, 1'b1, 32'h0, 32'd0);
        random_run(150);

        // Three wait states
        sel = 1'b1;
        w = 3;
        clear_model();
        do_reset();
        preload();
        for (int i = 0; i < 3; i++) instr(32'(i * 4), 1'b0, 1'b0, 32'd0, 32'd0);
        instr(32'h8, 1'b0, 1'b1, 32'h1C, 32'd0);
        random_run(60);
        instr(32'h0, 1'b1, 1'b0, 32'h1C, 32'h77);

        // Reset in the second cycle of a store must leave the word untouched
        i_addr = 32'h0;
        d_addr = 32'h1C;
        d_wdata = 32'hBAD0BAD0;
        d_we = 1'b1;
        d_oe = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_outputs();
        d_we = 1'b0;
        release_reset();
        instr(32'h1C, 1'b0, 1'b1, 32'h1C, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
